store_narrow: RTL and testbench

Store-side narrowing unit for the CPU model: the write-path counterpart of the immediate/load sign extender. It accepts a 32-bit register value with an access size and address offset, checks that the value fits the narrower width (signed or unsigned), and produces lane-replicated write data and byte enables. Results pass through a registered valid/ready pipeline with a one-entry skid buffer, and the unit keeps a saturating count of overflowing stores. It sits between the execute stage and the data-memory write port.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/store_format.sv | 42 ++++
 rtl/store_narrow.sv | 98 +++++++++
 tb/tb_store_narrow.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-model definitions: access-size encodings and the store-narrowing result record.
package cpu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
    logic        ovf;
    logic        misalign;
  } store_res_t;

endpackage

// File: rtl/store_format.sv
// Combinational store formatter: lane replication, byte enables, range and alignment checks.
module store_format
  import cpu_pkg::*;
(
  input  logic [31:0] in_data,
  input  logic [1:0]  in_size,
  input  logic [1:0]  in_addr,
  input  logic        in_sext,
  output store_res_t  res
);

  always_comb begin
    res      = '0;
    res.data = in_data;
    case (in_size)
      SZ_BYTE: begin
        res.data = {4{in_data[7:0]}};
        res.be   = 4'b0001 << in_addr;
        // Signed fit means every bit from the sign bit upward is a copy of it.
        res.ovf  = in_sext ? ~((&in_data[31:7]) | ~(|in_data[31:7])) : (|in_data[31:8]);
      end
      SZ_HALF: begin
        res.data     = {2{in_data[15:0]}};
        res.be       = in_addr[1] ? 4'b1100 : 4'b0011;
        res.ovf      = in_sext ? ~((&in_data[31:15]) | ~(|in_data[31:15])) :
                                 (|in_data[31:16]);
        res.misalign = in_addr[0];
      end
      SZ_WORD: begin
        res.be       = 4'b1111;
        res.misalign = |in_addr;
      end
      default: begin
        res.misalign = 1'b1;
      end
    endcase
    if (res.misalign) begin
      res.be = 4'b0000;
    end
  end

endmodule

// File: rtl/store_narrow.sv
// Store narrowing unit: formatter feeding an output register with a one-entry skid buffer,
// plus a saturating count of delivered overflowing stores.
module store_narrow
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_size,
  input  logic [1:0]       in_addr,
  input  logic             in_sext,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [3:0]       out_be,
  output logic             out_ovf,
  output logic             out_misalign,
  output logic [CNT_W-1:0] ovf_count
);

  store_res_t fmt;
  store_res_t out_q, out_d;
  store_res_t skid_q, skid_d;
  logic       out_valid_q, out_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       accept;
  logic       out_xfer;
  logic       out_free;

  store_format u_format (
    .in_data (in_data),
    .in_size (in_size),
    .in_addr (in_addr),
    .in_sext (in_sext),
    .res     (fmt)
  );

  assign in_ready = ~rst & ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign out_xfer = out_valid_q & out_ready;
  assign out_free = ~out_valid_q | out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    if (out_free) begin
      // A held skid item blocks input (in_ready = 0), so it always drains first.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = fmt;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = fmt;
      skid_valid_d = 1'b1;
    end
    if (out_xfer && out_q.ovf && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_q.data;
  assign out_be       = out_q.be;
  assign out_ovf      = out_q.ovf;
  assign out_misalign = out_q.misalign;
  assign ovf_count    = cnt_q;

endmodule

// File: tb/tb_store_narrow.sv
// Randomised bench for store_narrow: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_store_narrow;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic [1:0]  in_addr;
  logic        in_sext;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf, out_misalign;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic [15:0] ovf_count;

  logic        in_ready2, out_valid2, out_ovf2, out_misalign2;
  logic [31:0] out_data2;
  logic [3:0]  out_be2;
  logic [1:0]  ovf_count2;

  int checks = 0;
  int failures = 0;
  bit mon_on = 1'b0;

  always #5 clk = ~clk;

  store_narrow #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_size(in_size), .in_addr(in_addr), .in_sext(in_sext), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_be(out_be), .out_ovf(out_ovf),
    .out_misalign(out_misalign), .ovf_count(ovf_count)
  );

  store_narrow #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_size(in_size), .in_addr(in_addr), .in_sext(in_sext), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_be(out_be2), .out_ovf(out_ovf2),
    .out_misalign(out_misalign2), .ovf_count(ovf_count2)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
    logic        ovf;
    logic        mis;
  } item_t;

  item_t q[$];
  int    cnt_big = 0;
  int    cnt_small = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: value-range arithmetic and lane multiplication.
  function automatic item_t model(input logic [31:0] d, input logic [1:0] sz,
                                  input logic [1:0] a, input logic sx);
    item_t r;
    int    sv;
    sv    = $signed(d);
    r.data = d;
    r.ovf  = 1'b0;
    r.mis  = 1'b0;
    r.be   = 4'h0;
    case (sz)
      2'd0: begin
        r.data = {24'h0, d[7:0]} * 32'h0101_0101;
        r.be   = 4'(1 << a);
        r.ovf  = sx ? (sv < -128 || sv > 127) : (d > 32'd255);
      end
      2'd1: begin
        r.data = {16'h0, d[15:0]} * 32'h0001_0001;
        r.be   = (a >= 2) ? 4'hC : 4'h3;
        r.ovf  = sx ? (sv < -32768 || sv > 32767) : (d > 32'd65535);
        r.mis  = (a % 2) != 0;
      end
      2'd2: begin
        r.be  = 4'hF;
        r.mis = (a != 0);
      end
      default: r.mis = 1'b1;
    endcase
    if (r.mis) r.be = 4'h0;
    return r;
  endfunction

  // Per-cycle compare; inputs are stable here and are what the next rising edge samples.
  always @(negedge clk) begin
    if (mon_on) begin
      bit    rdy_exp;
      item_t it;
      rdy_exp = !rst && (q.size() < 2);
      chk("in_ready", in_ready, rdy_exp);
      chk("out_valid", out_valid, q.size() > 0);
      chk("small_out_valid", out_valid2, q.size() > 0);
      chk("ovf_count", ovf_count, cnt_big);
      chk("small_ovf_count", ovf_count2, cnt_small);
      if (q.size() > 0) begin
        chk("out_data", out_data, q[0].data);
        chk("out_be", out_be, q[0].be);
        chk("out_ovf", out_ovf, q[0].ovf);
        chk("out_misalign", out_misalign, q[0].mis);
      end
      if (rst) begin
        q.delete();
        cnt_big = 0;
        cnt_small = 0;
      end else begin
        if (q.size() > 0 && out_ready) begin
          it = q.pop_front();
          if (it.ovf) begin
            if (cnt_big < 65535) cnt_big++;
            if (cnt_small < 3) cnt_small++;
          end
        end
        if (in_valid && rdy_exp) q.push_back(model(in_data, in_size, in_addr, in_sext));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one item for one edge; callers only use it when the unit can accept.
  task automatic put(input logic [31:0] d, input logic [1:0] sz, input logic [1:0] a,
                     input logic sx);
    in_valid = 1'b1;
    in_data  = d;
    in_size  = sz;
    in_addr  = a;
    in_sext  = sx;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int t;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_size = '0; in_addr = '0; in_sext = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    mon_on = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_out_data", out_data, 32'h0);
    chk("post_rst_out_be", out_be, 4'h0);
    chk("post_rst_count", ovf_count, 16'd0);

    // Signed byte, lane 2.
    step();
    out_ready = 1'b1;
    put(32'hFFFF_FF80, 2'b00, 2'd2, 1'b1);
    @(negedge clk);
    chk("byte_valid", out_valid, 1'b1);
    chk("byte_data", out_data, 32'h8080_8080);
    chk("byte_be", out_be, 4'b0100);
    chk("byte_ovf", out_ovf, 1'b0);
    chk("byte_mis", out_misalign, 1'b0);

    put(32'h0000_0080, 2'b00, 2'd0, 1'b1);
    @(negedge clk);
    chk("byte_s_ovf", out_ovf, 1'b1);
    put(32'h0000_0080, 2'b00, 2'd0, 1'b0);
    @(negedge clk);
    chk("byte_u_ovf", out_ovf, 1'b0);
    step();
    @(negedge clk);
    chk("count_one", ovf_count, 16'd1);

    put(32'h0000_1234, 2'b01, 2'd1, 1'b0);
    @(negedge clk);
    chk("half_mis_be", out_be, 4'b0000);
    chk("half_mis", out_misalign, 1'b1);
    put(32'h1234_5678, 2'b10, 2'd2, 1'b0);
    @(negedge clk);
    chk("word_mis", out_misalign, 1'b1);
    put(32'h1234_5678, 2'b11, 2'd0, 1'b1);
    @(negedge clk);
    chk("ill_mis", out_misalign, 1'b1);
    chk("ill_ovf", out_ovf, 1'b0);

    // A, B, C under a stalled output.
    step();
    out_ready = 1'b0;
    put(32'h0000_00AA, 2'b00, 2'd0, 1'b0);
    put(32'h0000_BBBB, 2'b01, 2'd2, 1'b0);
    in_valid = 1'b1; in_data = 32'hCCCC_CCCC; in_size = 2'b10; in_addr = 2'd0;
    step();
    @(negedge clk);
    chk("abc_in_ready", in_ready, 1'b0);
    chk("abc_out_a", out_data, 32'hAAAA_AAAA);
    step();
    @(negedge clk);
    chk("abc_stable", out_data, 32'hAAAA_AAAA);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(in_ready && in_valid) && t < 20);
    chk("abc_accept_timeout", t < 20, 1'b1);
    step();
    in_valid = 1'b0;
    repeat (3) step();

    // Saturation of the narrow counter, then reset with the skid full.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) put(32'h0000_0100, 2'b00, 2'd0, 1'b0);
    step();
    @(negedge clk);
    chk("small_sat", ovf_count2, 2'd3);
    chk("big_four", ovf_count, 16'd4);
    step();
    out_ready = 1'b0;
    put(32'h0000_0100, 2'b00, 2'd0, 1'b0);
    put(32'h0000_0200, 2'b00, 2'd0, 1'b0);
    @(negedge clk);
    chk("skid_full", in_ready, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_count", ovf_count, 16'd0);
    chk("rst_in_ready_after", in_ready, 1'b1);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      step();
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      in_size   = 2'($urandom_range(0, 3));
      in_addr   = 2'($urandom_range(0, 3));
      in_sext   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: in_data = $urandom();
        1: in_data = 32'($urandom_range(0, 511)) - 32'd256;
        2: in_data = 32'($urandom_range(0, 131071)) - 32'd65536;
        default: in_data = 32'($urandom_range(0, 131071));
      endcase
    end
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
